// File: rtl/posit_mul_arbiter_if.sv
// Request/response bundle between posit compute clients and the shared-multiplier arbiter.
// The arbiter takes the slave view; clients (or a bench) take the master view.
interface posit_mul_arbiter_if #(
  parameter int unsigned N    = 8,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_in1;
  logic [NREQ*N-1:0] req_in2;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [N-1:0]      rsp_result;
  logic [IDW-1:0]    rsp_id;

  modport slave (
    input  req_valid, req_in1, req_in2, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_id
  );

  modport master (
    output req_valid, req_in1, req_in2, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_id
  );
endinterface

// File: rtl/posit_mul_arbiter.sv
// Round-robin arbiter sharing one external combinational posit multiplier among NREQ
// requesters; one operation in flight, result returned with the issuing requester's ID.
module posit_mul_arbiter #(
  parameter int unsigned N    = 8,
  parameter int unsigned ES   = 3,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  posit_mul_arbiter_if.slave     bus,
  output logic [N-1:0]           mul_in1,
  output logic [N-1:0]           mul_in2,
  input  logic [N-1:0]           mul_out,
  output logic                   busy
);

  if (NREQ < 2 || ES >= N) begin : g_bad_params
    $error("posit_mul_arbiter: need NREQ >= 2 and ES < N");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id_q;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] ptr_next;
  logic           grant_found;

  // Search starts at rr_ptr and wraps modulo NREQ, so NREQ need not be a power of two.
  always_comb begin
    int unsigned cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int unsigned o = 0; o < NREQ; o++) begin
      cand = (32'(rr_ptr) + o) % NREQ;
      if (!grant_found && bus.req_valid[IDW'(cand)]) begin
        grant_found = 1'b1;
        grant_id    = IDW'(cand);
      end
    end
    ptr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == S_IDLE && grant_found) begin
      bus.req_ready[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (grant_found) state_next = S_EXEC;
      S_EXEC:  state_next = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr         <= '0;
      id_q           <= '0;
      mul_in1        <= '0;
      mul_in2        <= '0;
      bus.rsp_result <= '0;
      bus.rsp_id     <= '0;
    end else begin
      if (state == S_IDLE && grant_found) begin
        mul_in1 <= bus.req_in1[grant_id*N +: N];
        mul_in2 <= bus.req_in2[grant_id*N +: N];
        id_q    <= grant_id;
        rr_ptr  <= ptr_next;
      end
      if (state == S_EXEC) begin
        bus.rsp_result <= mul_out;
        bus.rsp_id     <= id_q;
      end
    end
  end

  // rsp_valid is exactly "in RESP": set on the EXEC->RESP edge, cleared on the handshake edge.
  assign bus.rsp_valid = (state == S_RESP);
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_posit_mul_arbiter.sv
// Directed scoreboard bench for posit_mul_arbiter; the multiplier is a small posit(8,3)
// model that handles zero and positive powers of two with regime k=0.
module tb_posit_mul_arbiter;
  localparam int unsigned N    = 8;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [N-1:0]   res;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] mul_in1;
  logic [N-1:0] mul_in2;
  logic [N-1:0] mul_out;
  logic         busy;
  int           total = 0;
  int           bad = 0;
  int           cyc_cnt = 0;
  exp_t         exp_q[$];

  posit_mul_arbiter_if #(.N(N), .NREQ(NREQ), .IDW(IDW)) bus ();

  posit_mul_arbiter #(.N(N), .ES(3), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .mul_in1 (mul_in1),
    .mul_in2 (mul_in2),
    .mul_out (mul_out),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  // 0x40 + 4*e encodes 2^e (regime "10", 3-bit exponent e, zero fraction).
  function automatic logic [7:0] pmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] ea;
    logic [7:0] eb;
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    ea = (a - 8'h40) >> 2;
    eb = (b - 8'h40) >> 2;
    return 8'h40 + ((ea + eb) << 2);
  endfunction

  assign mul_out = pmul(mul_in1, mul_in2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp actual id=%0d result=%0h required=no response",
                 bus.rsp_id, bus.rsp_result);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
        chk("rsp_result", 32'(bus.rsp_result), 32'(e.res));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int unsigned id, input logic [7:0] res);
    exp_t e;
    e.id  = IDW'(id);
    e.res = res;
    exp_q.push_back(e);
  endtask

  task automatic set_op(input int unsigned i, input logic [7:0] a, input logic [7:0] b);
    bus.req_in1[i*N +: N] = a;
    bus.req_in2[i*N +: N] = b;
  endtask

  task automatic wait_grant(output logic [NREQ-1:0] g);
    int n;
    n = 0;
    #1;
    while (bus.req_ready == '0 && n < 12) begin
      cyc();
      n++;
    end
    g = bus.req_ready;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      cyc();
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    cyc();
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    #150000;
    $display("FAIL watchdog actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NREQ-1:0] g;
    int              prev;
    int unsigned     eid;

    bus.req_valid = '0;
    bus.req_in1   = '0;
    bus.req_in2   = '0;
    bus.rsp_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mul_in1", 32'(mul_in1), 32'd0);
    chk("rst_mul_in2", 32'(mul_in2), 32'd0);
    chk("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    rst_n = 1'b1;
    cyc();

    // 1) single request: 2.0 * 4.0 = 8.0
    set_op(0, 8'h44, 8'h48);
    bus.req_valid = 4'b0001;
    #1;
    chk("t1_grant", 32'(bus.req_ready), 32'h1);
    push(0, 8'h4C);
    cyc();
    bus.req_valid = '0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_mul_in1", 32'(mul_in1), 32'h44);
    chk("t1_mul_in2", 32'(mul_in2), 32'h48);
    chk("t1_rsp_early", 32'(bus.rsp_valid), 32'd0);
    cyc();
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    cyc();
    chk("t1_idle", 32'(busy), 32'd0);
    drain("t1_drain");

    // 2) all requesters valid: order 0,1,2,3,0, three cycles apart
    do_reset();
    for (int unsigned i = 0; i < NREQ; i++) set_op(i, 8'(8'h40 + 4 * i), 8'h44);
    bus.req_valid = 4'b1111;
    prev = 0;
    for (int unsigned k = 0; k < 5; k++) begin
      eid = k % NREQ;
      wait_grant(g);
      chk("t2_grant", 32'(g), 32'(1) << eid);
      push(eid, 8'(8'h44 + 4 * eid));
      if (k > 0) chk("t2_interval", 32'(cyc_cnt - prev), 32'd3);
      prev = cyc_cnt;
      cyc();
    end
    bus.req_valid = '0;
    drain("t2_drain");

    // 3) stall in RESP for 5 cycles, then 4) requester 2 wins with rr_ptr=2
    set_op(1, 8'h48, 8'h48);
    bus.req_valid = 4'b0010;
    wait_grant(g);
    chk("t3_grant", 32'(g), 32'h2);
    push(1, 8'h50);
    cyc();
    bus.rsp_ready = 1'b0;
    set_op(0, 8'h44, 8'h44);
    set_op(2, 8'h40, 8'h00);
    set_op(3, 8'h4C, 8'h40);
    bus.req_valid = 4'b1101;
    cyc();
    for (int unsigned k = 0; k < 5; k++) begin
      chk("t3_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("t3_hold_result", 32'(bus.rsp_result), 32'h50);
      chk("t3_hold_id", 32'(bus.rsp_id), 32'd1);
      chk("t3_no_grant", 32'(bus.req_ready), 32'd0);
      cyc();
    end
    bus.rsp_ready = 1'b1;
    cyc();
    chk("t4_grant2", 32'(bus.req_ready), 32'h4);
    push(2, 8'h00);
    cyc();
    bus.req_valid = 4'b1001;
    chk("t4_mul_in2", 32'(mul_in2), 32'h00);
    wait_grant(g);
    chk("t4_grant3", 32'(g), 32'h8);
    push(3, 8'h4C);
    cyc();
    wait_grant(g);
    chk("t4_grant0", 32'(g), 32'h1);
    push(0, 8'h48);
    cyc();
    bus.req_valid = '0;
    drain("t4_drain");

    // 6) operands changed after the grant cycle are ignored
    set_op(1, 8'h40, 8'h40);
    bus.req_valid = 4'b0010;
    wait_grant(g);
    chk("t6_grant", 32'(g), 32'h2);
    push(1, 8'h40);
    cyc();
    set_op(1, 8'h4C, 8'h4C);
    bus.req_valid = '0;
    chk("t6_mul_in1", 32'(mul_in1), 32'h40);
    drain("t6_drain");

    // 5a) reset during EXEC
    set_op(2, 8'h44, 8'h44);
    bus.req_valid = 4'b0100;
    wait_grant(g);
    chk("t5a_grant", 32'(g), 32'h4);
    cyc();
    bus.req_valid = '0;
    chk("t5a_exec_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5a_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t5a_busy", 32'(busy), 32'd0);
    cyc();
    rst_n = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      cyc();
      chk("t5a_no_stale", 32'(bus.rsp_valid), 32'd0);
    end

    // 5b) reset during RESP, then pointer must restart at 0
    set_op(3, 8'h4C, 8'h4C);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1000;
    wait_grant(g);
    chk("t5b_grant", 32'(g), 32'h8);
    cyc();
    bus.req_valid = '0;
    cyc();
    chk("t5b_in_resp", 32'(bus.rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5b_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t5b_busy", 32'(busy), 32'd0);
    chk("t5b_rsp_result", 32'(bus.rsp_result), 32'd0);
    chk("t5b_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("t5b_mul_in1", 32'(mul_in1), 32'd0);
    cyc();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    set_op(0, 8'h48, 8'h44);
    bus.req_valid = 4'b1111;
    wait_grant(g);
    chk("t5b_ptr_zero", 32'(g), 32'h1);
    push(0, 8'h4C);
    cyc();
    bus.req_valid = '0;
    drain("t5b_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
